fetch_stage: RTL and testbench

- First stage of the LC-3b pipeline. Owns the PC and the instruction-cache request, and fills the DE latch (de_npc, de_ir, de_v) consumed by the decode stage.
- Honours decode dependency stalls, memory stalls and branch stalls from DE/AGEX/MEM.
- Accepts PC redirects from the MEM stage for taken branches, jumps and traps.

---
 rtl/lc3b_pkg.sv | 20 ++
 rtl/pc_unit.sv | 42 ++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_pkg.sv
// rtl/lc3b_pkg.sv - shared LC-3b fetch encodings, reset PC and helpers
package lc3b_pkg;

   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

   localparam logic [1:0] PCMUX_SEQ    = 2'd0;
   localparam logic [1:0] PCMUX_TARGET = 2'd1;
   localparam logic [1:0] PCMUX_TRAP   = 2'd2;

   typedef enum logic [1:0] {
      FE_RUN    = 2'd0,
      FE_MISS   = 2'd1,
      FE_BRWAIT = 2'd2
   } fe_state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
      return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
   endfunction

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - LC-3b program counter register, next-PC mux and +2 adder
module pc_unit
   import lc3b_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic        advance,
   input  logic [1:0]  pcmux,
   input  logic [15:0] target_pc,
   input  logic [15:0] trap_pc,
   output logic [15:0] pc,
   output logic [15:0] pc_plus2
);

   logic [15:0] pc_q, pc_d;

   always_comb begin
      pc_plus2 = pc_q + 16'd2;
      pc_d     = pc_q;
      // Redirect from MEM outranks sequential fetch; reserved select falls back to PC+2.
      if (redirect) begin
         case (pcmux)
            PCMUX_TARGET: pc_d = target_pc;
            PCMUX_TRAP:   pc_d = trap_pc;
            default:      pc_d = pc_plus2;
         endcase
      end else if (advance) begin
         pc_d = pc_plus2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LC-3b fetch stage: PC, icache request, DE latch; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
   import lc3b_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] icache_addr,
   output logic        icache_req,
   input  logic        icache_r,
   input  logic [15:0] icache_data,
   input  logic        dep_stall,
   input  logic        mem_stall,
   input  logic        v_de_br_stall,
   input  logic        v_agex_br_stall,
   input  logic        v_mem_br_stall,
   input  logic [1:0]  mem_pcmux,
   input  logic [15:0] target_pc,
   input  logic [15:0] trap_pc,
   output logic [15:0] de_npc,
   output logic [15:0] de_ir,
   output logic        de_v,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles,
   output logic [31:0] perf_miss,
`endif
   output logic [1:0]  fe_state
);

   fe_state_e   state_q, state_d;
   logic        any_br, ld_de, redirect, brwait, fetch_ok;
   logic [15:0] pc, pc_plus2;
   logic [15:0] de_npc_q, de_npc_d, de_ir_q, de_ir_d;
   logic        de_v_q, de_v_d;

   always_comb begin
      any_br   = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
      ld_de    = ~dep_stall & ~mem_stall;
      redirect = v_mem_br_stall & ~mem_stall;
      brwait   = (state_q == FE_BRWAIT);
      fetch_ok = icache_r & ~any_br & ~brwait;

      de_npc_d = de_npc_q;
      de_ir_d  = de_ir_q;
      de_v_d   = de_v_q;
      if (ld_de) begin
         de_npc_d = pc_plus2;
         de_ir_d  = icache_data;
         de_v_d   = fetch_ok;
      end

      state_d = state_q;
      if (!mem_stall) begin
         case (state_q)
            FE_RUN:    if (any_br) state_d = FE_BRWAIT;
                       else if (!icache_r) state_d = FE_MISS;
            FE_MISS:   if (any_br) state_d = FE_BRWAIT;
                       else if (icache_r) state_d = FE_RUN;
            FE_BRWAIT: if (redirect) state_d = FE_RUN;
            default:   state_d = FE_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= FE_RUN;
         de_npc_q <= 16'h0000;
         de_ir_q  <= 16'h0000;
         de_v_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         de_npc_q <= de_npc_d;
         de_ir_q  <= de_ir_d;
         de_v_q   <= de_v_d;
      end
   end

   pc_unit #(.RESET_PC(RESET_PC)) u_pc (
      .clk       (clk),
      .reset     (reset),
      .redirect  (redirect),
      .advance   (fetch_ok & ld_de),
      .pcmux     (mem_pcmux),
      .target_pc (target_pc),
      .trap_pc   (trap_pc),
      .pc        (pc),
      .pc_plus2  (pc_plus2)
   );

   assign icache_addr = pc;
   assign icache_req  = ~brwait;
   assign de_npc      = de_npc_q;
   assign de_ir       = de_ir_q;
   assign de_v        = de_v_q;
   assign fe_state    = state_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetched_q, fetched_d, bubbles_q, bubbles_d, miss_q, miss_d;

   always_comb begin
      fetched_d = sat_inc(fetched_q, ld_de & fetch_ok);
      bubbles_d = sat_inc(bubbles_q, ld_de & ~fetch_ok);
      miss_d    = sat_inc(miss_q, (state_q == FE_RUN) && (state_d == FE_MISS));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetched_q <= 32'd0;
         bubbles_q <= 32'd0;
         miss_q    <= 32'd0;
      end else begin
         fetched_q <= fetched_d;
         bubbles_q <= bubbles_d;
         miss_q    <= miss_d;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_bubbles = bubbles_q;
   assign perf_miss    = miss_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage (vector table, corner sequences, random vs model)
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        icache_r, dep_stall, mem_stall;
   logic        v_de_br_stall, v_agex_br_stall, v_mem_br_stall;
   logic [1:0]  mem_pcmux;
   logic [15:0] icache_data, target_pc, trap_pc;
   logic [15:0] icache_addr, de_npc, de_ir;
   logic        icache_req, de_v;
   logic [1:0]  fe_state;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_bubbles, perf_miss;
`endif

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk             (clk),
      .reset           (reset),
      .icache_addr     (icache_addr),
      .icache_req      (icache_req),
      .icache_r        (icache_r),
      .icache_data     (icache_data),
      .dep_stall       (dep_stall),
      .mem_stall       (mem_stall),
      .v_de_br_stall   (v_de_br_stall),
      .v_agex_br_stall (v_agex_br_stall),
      .v_mem_br_stall  (v_mem_br_stall),
      .mem_pcmux       (mem_pcmux),
      .target_pc       (target_pc),
      .trap_pc         (trap_pc),
      .de_npc          (de_npc),
      .de_ir           (de_ir),
      .de_v            (de_v),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetched    (perf_fetched),
      .perf_bubbles    (perf_bubbles),
      .perf_miss       (perf_miss),
`endif
      .fe_state        (fe_state)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   typedef struct {
      logic        r;
      logic [15:0] data;
      logic        dep, ms, vde, vag, vme;
      logic [1:0]  mux;
      logic [15:0] tgt, trap;
      logic [15:0] e_pc, e_ir, e_npc;
      logic        e_v;
      logic [1:0]  e_st;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [15:0] data, input logic dep, input logic ms,
                      input logic vde, input logic vag, input logic vme, input logic [1:0] mux,
                      input logic [15:0] tgt, input logic [15:0] trap,
                      input logic [15:0] e_pc, input logic [15:0] e_ir, input logic [15:0] e_npc,
                      input logic e_v, input logic [1:0] e_st);
      vec_t v;
      v.r = r; v.data = data; v.dep = dep; v.ms = ms; v.vde = vde; v.vag = vag; v.vme = vme;
      v.mux = mux; v.tgt = tgt; v.trap = trap;
      v.e_pc = e_pc; v.e_ir = e_ir; v.e_npc = e_npc; v.e_v = e_v; v.e_st = e_st;
      vecs.push_back(v);
   endtask

   task automatic add_hit(input logic [15:0] data, input logic [15:0] pc_after);
      add(1, data, 0, 0, 0, 0, 0, 0, 0, 0, pc_after, data, pc_after, 1, 0);
   endtask

   task automatic drive(input logic r, input logic [15:0] data, input logic dep, input logic ms,
                        input logic vde, input logic vag, input logic vme, input logic [1:0] mux,
                        input logic [15:0] tgt, input logic [15:0] trap);
      icache_r = r; icache_data = data; dep_stall = dep; mem_stall = ms;
      v_de_br_stall = vde; v_agex_br_stall = vag; v_mem_br_stall = vme;
      mem_pcmux = mux; target_pc = tgt; trap_pc = trap;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [15:0] pc, input logic [15:0] ir,
                             input logic [15:0] npc, input logic v, input logic [1:0] st);
      chk({tag, " pc"},    {16'h0, icache_addr}, {16'h0, pc});
      chk({tag, " de_ir"}, {16'h0, de_ir},       {16'h0, ir});
      chk({tag, " de_npc"},{16'h0, de_npc},      {16'h0, npc});
      chk({tag, " de_v"},  {31'h0, de_v},        {31'h0, v});
      chk({tag, " state"}, {30'h0, fe_state},    {30'h0, st});
      chk({tag, " req"},   {31'h0, icache_req},  {31'h0, (st != 2'd2)});
   endtask

   // Reference model: architectural view of the fetch stage from its rules.
   logic [15:0] m_pc, m_ir, m_npc;
   logic        m_v;
   int          m_mode;           // 0 running, 1 waiting on miss, 2 waiting on branch
   longint      m_fet, m_bub, m_miss;

   task automatic model_reset();
      m_pc = 16'h0000; m_ir = 16'h0000; m_npc = 16'h0000; m_v = 0; m_mode = 0;
      m_fet = 0; m_bub = 0; m_miss = 0;
   endtask

   task automatic model_step();
      bit br, load, redir, valid_word;
      int next_mode;
      logic [15:0] next_pc;
      br         = v_de_br_stall || v_agex_br_stall || v_mem_br_stall;
      load       = !dep_stall && !mem_stall;
      redir      = v_mem_br_stall && !mem_stall;
      valid_word = icache_r && !br && (m_mode != 2);
      next_pc = m_pc;
      if (redir)
         next_pc = (mem_pcmux == 1) ? target_pc : (mem_pcmux == 2) ? trap_pc : 16'((int'(m_pc) + 2) % 65536);
      else if (valid_word && load)
         next_pc = 16'((int'(m_pc) + 2) % 65536);
      next_mode = m_mode;
      if (!mem_stall) begin
         if (m_mode == 2) begin
            if (redir) next_mode = 0;
         end else if (br) next_mode = 2;
         else if (m_mode == 0 && !icache_r) next_mode = 1;
         else if (m_mode == 1 && icache_r) next_mode = 0;
      end
      if (load) begin
         m_ir  = icache_data;
         m_npc = 16'((int'(m_pc) + 2) % 65536);
         m_v   = valid_word;
         if (valid_word) m_fet = (m_fet < 64'hFFFF_FFFF) ? m_fet + 1 : m_fet;
         else            m_bub = (m_bub < 64'hFFFF_FFFF) ? m_bub + 1 : m_bub;
      end
      if (m_mode == 0 && next_mode == 1) m_miss = (m_miss < 64'hFFFF_FFFF) ? m_miss + 1 : m_miss;
      m_pc   = next_pc;
      m_mode = next_mode;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
      tick(); tick();
      reset = 1'b0;
      check_outs("reset", 16'h0000, 16'h0000, 16'h0000, 0, 0);
`ifdef FETCH_PERF_CNT_EN
      chk("reset perf_fetched", perf_fetched, 0);
      chk("reset perf_bubbles", perf_bubbles, 0);
      chk("reset perf_miss", perf_miss, 0);
`endif

      // r, data, dep, ms, vde, vag, vme, mux, tgt, trap, e_pc, e_ir, e_npc, e_v, e_st
      add_hit(16'h1261, 16'h0002);
      add_hit(16'h1482, 16'h0004);
      for (int i = 0; i < 6; i++) add_hit(16'hA000 + 16'(i), 16'h0006 + 16'(2 * i));
      for (int i = 0; i < 3; i++) add(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0012, 0, 1);
      add_hit(16'h3333, 16'h0012);
      for (int i = 0; i < 2; i++) add(1, 16'h4444, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0012, 16'h3333, 16'h0012, 1, 0);
      add_hit(16'h5555, 16'h0014);
      for (int i = 0; i < 6; i++) add_hit(16'hB000 + 16'(i), 16'h0016 + 16'(2 * i));
      add(1, 16'h6666, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0020, 16'h6666, 16'h0022, 0, 2);
      add(1, 16'h7777, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0020, 16'h7777, 16'h0022, 0, 2);
      add(1, 16'h8888, 0, 0, 0, 0, 1, 1, 16'h0100, 16'h0000, 16'h0100, 16'h8888, 16'h0022, 0, 0);
      add_hit(16'h9999, 16'h0102);
      add(1, 16'hAAAA, 0, 1, 0, 0, 1, 2, 16'h0000, 16'h0400, 16'h0102, 16'h9999, 16'h0102, 1, 0);
      add(1, 16'hAAAA, 0, 0, 0, 0, 1, 2, 16'h0000, 16'h0400, 16'h0400, 16'hAAAA, 16'h0104, 0, 2);
      add(1, 16'hBBBB, 0, 0, 0, 0, 1, 1, 16'hFFFE, 16'h0000, 16'hFFFE, 16'hBBBB, 16'h0402, 0, 0);
      add(1, 16'hCCCC, 0, 0, 0, 0, 1, 0, 16'h1234, 16'h5678, 16'h0000, 16'hCCCC, 16'h0000, 0, 2);
      add(1, 16'hDDDD, 0, 0, 0, 0, 1, 3, 16'h1234, 16'h5678, 16'h0002, 16'hDDDD, 16'h0002, 0, 0);
      add_hit(16'hEEEE, 16'h0004);
      add(1, 16'h1111, 1, 0, 0, 0, 1, 1, 16'h0201, 16'h0000, 16'h0201, 16'hEEEE, 16'h0004, 1, 2);
      add(0, 16'h2222, 0, 0, 0, 0, 1, 2, 16'h0000, 16'h0300, 16'h0300, 16'h2222, 16'h0203, 0, 0);
      add(0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0300, 16'h0000, 16'h0302, 0, 1);
      add(1, 16'h3131, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0300, 16'h3131, 16'h0302, 0, 2);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r, vecs[i].data, vecs[i].dep, vecs[i].ms, vecs[i].vde, vecs[i].vag,
               vecs[i].vme, vecs[i].mux, vecs[i].tgt, vecs[i].trap);
         tick();
         check_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ir, vecs[i].e_npc,
                    vecs[i].e_v, vecs[i].e_st);
      end

      // Reset while in BRWAIT, with a redirect pending, must win.
      reset = 1'b1;
      drive(1, 16'hFFFF, 0, 0, 1, 1, 1, 1, 16'h7777, 16'h8888);
      tick();
      reset = 1'b0;
      check_outs("rst_brwait", 16'h0000, 16'h0000, 16'h0000, 0, 0);

      // Enter MISS, then reset mid-miss.
      drive(0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
      tick();
      chk("miss before reset state", {30'h0, fe_state}, 32'd1);
      reset = 1'b1;
      drive(1, 16'h5A5A, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
      tick();
      reset = 1'b0;
      check_outs("rst_miss", 16'h0000, 16'h0000, 16'h0000, 0, 0);

`ifdef FETCH_PERF_CNT_EN
      for (int i = 0; i < 4; i++) begin
         drive(1, 16'h0100 + 16'(i), 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
         tick();
      end
      drive(0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
      tick();
      drive(1, 16'h0200, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0);
      tick();
      drive(1, 16'h0201, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0);
      tick();
      chk("perf_fetched seq", perf_fetched, 4);
      chk("perf_miss seq", perf_miss, 1);
      chk("perf_bubbles seq", perf_bubbles, 3);
`endif

      // Randomized run against the reference model, with occasional resets.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      for (int k = 0; k < 1500; k++) begin
         reset = ($urandom_range(63) == 0);
         drive($urandom_range(3) != 0, 16'($urandom), $urandom_range(6) == 0, $urandom_range(9) == 0,
               $urandom_range(12) == 0, $urandom_range(19) == 0, $urandom_range(11) == 0,
               2'($urandom_range(3)), 16'($urandom), 16'($urandom));
         tick();
         if (reset) model_reset();
         else       model_step();
         reset = 1'b0;
         check_outs($sformatf("rnd%0d", k), m_pc, m_ir, m_npc, m_v, 2'(m_mode));
`ifdef FETCH_PERF_CNT_EN
         chk($sformatf("rnd%0d perf_fetched", k), perf_fetched, 32'(m_fet));
         chk($sformatf("rnd%0d perf_bubbles", k), perf_bubbles, 32'(m_bub));
         chk($sformatf("rnd%0d perf_miss", k), perf_miss, 32'(m_miss));
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
